// File: rtl/simon_round_ctrl_if.sv
// -----------------------------------------------------------------------------
// simon_round_ctrl_if
//
// Bundles every handshake and data signal of the SIMON round controller.
// The controller connects through the slave modport. The surrounding system
// (cipher top-level, round unit and round-key store) connects through the
// master modport.
//
// Signal groups:
//   input side  : mode, i_block, i_valid, i_ready
//   output side : o_block, o_valid, o_ready
//   key store   : key_rd, key_addr, key_data (data valid 1 cycle after key_rd)
//   round unit  : r_mode, r_block, r_key, r_valid, r_ready, r_result, r_done
// -----------------------------------------------------------------------------
interface simon_round_ctrl_if #(
    parameter int BLOCK_WIDTH = 128,
    parameter int KEY_WIDTH   = 64,
    parameter int CNT_WIDTH   = 7
);
    logic                   mode;
    logic [BLOCK_WIDTH-1:0] i_block;
    logic                   i_valid;
    logic                   i_ready;

    logic [BLOCK_WIDTH-1:0] o_block;
    logic                   o_valid;
    logic                   o_ready;

    logic                   key_rd;
    logic [CNT_WIDTH-1:0]   key_addr;
    logic [KEY_WIDTH-1:0]   key_data;

    logic                   r_mode;
    logic [BLOCK_WIDTH-1:0] r_block;
    logic [KEY_WIDTH-1:0]   r_key;
    logic                   r_valid;
    logic                   r_ready;
    logic [BLOCK_WIDTH-1:0] r_result;
    logic                   r_done;

    // Controller view.
    modport slave (
        input  mode, i_block, i_valid, o_ready, key_data, r_ready, r_result, r_done,
        output i_ready, o_block, o_valid, key_rd, key_addr, r_mode, r_block, r_key, r_valid
    );

    // Surrounding-system view.
    modport master (
        output mode, i_block, i_valid, o_ready, key_data, r_ready, r_result, r_done,
        input  i_ready, o_block, o_valid, key_rd, key_addr, r_mode, r_block, r_key, r_valid
    );
endinterface

// File: rtl/simon_round_ctrl.sv
// -----------------------------------------------------------------------------
// simon_round_ctrl
//
// Sequencing controller for the SIMON round datapath. Accepts one plaintext
// block plus a mode, then per round: reads the round key, issues block and key
// to the external round unit, waits for its result. After 44 rounds
// (mode 0, SIMON 64/128) or 68 rounds (mode 1, SIMON 128/128) the block is
// returned on the output valid/ready port.
//
// Ports:
//   ck    : clock
//   nrst  : synchronous active-low reset
//   bus   : simon_round_ctrl_if.slave (input, output, key-store and
//           round-unit handshakes)
//
// In mode 0 only the lower half of the block and of the round key is
// meaningful; the upper halves are held at zero everywhere in the controller.
// -----------------------------------------------------------------------------
module simon_round_ctrl #(
    parameter int BLOCK_WIDTH = 128,
    parameter int KEY_WIDTH   = 64,
    parameter int ROUNDS_64   = 44,
    parameter int ROUNDS_128  = 68,
    parameter int CNT_WIDTH   = 7
) (
    input  logic              ck,
    input  logic              nrst,
    simon_round_ctrl_if.slave bus
);

    localparam int HALF_BLOCK = BLOCK_WIDTH / 2;
    localparam int HALF_KEY   = KEY_WIDTH / 2;

    localparam logic [CNT_WIDTH-1:0] LAST_64  = CNT_WIDTH'(ROUNDS_64 - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_128 = CNT_WIDTH'(ROUNDS_128 - 1);

    typedef enum logic [2:0] {
        IDLE,
        KEY_REQ,
        KEY_WAIT,
        ISSUE,
        WAIT_RES,
        OUT
    } state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   round_cnt;
    logic [BLOCK_WIDTH-1:0] block_q;
    logic [BLOCK_WIDTH-1:0] o_block_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic                   mode_q;
    logic                   i_ready_q;
    logic                   o_valid_q;
    logic                   key_rd_q;
    logic                   r_valid_q;

    logic [CNT_WIDTH-1:0]   last_round;

    // Mode 0 carries a 64-bit block in the lower half; clear the rest.
    function automatic logic [BLOCK_WIDTH-1:0] mask_block(input logic m,
                                                          input logic [BLOCK_WIDTH-1:0] b);
        return m ? b : {{HALF_BLOCK{1'b0}}, b[HALF_BLOCK-1:0]};
    endfunction

    function automatic logic [KEY_WIDTH-1:0] mask_key(input logic m,
                                                      input logic [KEY_WIDTH-1:0] k);
        return m ? k : {{HALF_KEY{1'b0}}, k[HALF_KEY-1:0]};
    endfunction

    assign last_round = mode_q ? LAST_128 : LAST_64;

    always_ff @(posedge ck) begin
        // NOTE: the synchronous reset also clears the datapath registers so
        // that every output is at a defined value right after reset.
        if (!nrst) begin
            state     <= IDLE;
            round_cnt <= '0;
            block_q   <= '0;
            o_block_q <= '0;
            key_q     <= '0;
            mode_q    <= 1'b0;
            i_ready_q <= 1'b1;
            o_valid_q <= 1'b0;
            key_rd_q  <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            // NOTE: key_rd is a one-cycle strobe: this default is overridden by
            // the later non-blocking assignment on the cycles entering KEY_REQ.
            key_rd_q <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (bus.i_valid && i_ready_q) begin
                        mode_q    <= bus.mode;
                        block_q   <= mask_block(bus.mode, bus.i_block);
                        round_cnt <= '0;
                        i_ready_q <= 1'b0;
                        key_rd_q  <= 1'b1;
                        state     <= KEY_REQ;
                    end
                end

                KEY_REQ: begin
                    state <= KEY_WAIT;
                end

                // The key store answers exactly one cycle after the strobe.
                KEY_WAIT: begin
                    key_q     <= mask_key(mode_q, bus.key_data);
                    r_valid_q <= 1'b1;
                    state     <= ISSUE;
                end

                ISSUE: begin
                    if (bus.r_ready) begin
                        r_valid_q <= 1'b0;
                        state     <= WAIT_RES;
                    end
                end

                // r_done is only honoured here; pulses in other states are dropped.
                WAIT_RES: begin
                    if (bus.r_done) begin
                        block_q <= mask_block(mode_q, bus.r_result);
                        if (round_cnt == last_round) begin
                            o_block_q <= mask_block(mode_q, bus.r_result);
                            o_valid_q <= 1'b1;
                            state     <= OUT;
                        end else begin
                            round_cnt <= round_cnt + 1'b1;
                            key_rd_q  <= 1'b1;
                            state     <= KEY_REQ;
                        end
                    end
                end

                OUT: begin
                    if (bus.o_ready) begin
                        o_valid_q <= 1'b0;
                        i_ready_q <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.i_ready  = i_ready_q;
    assign bus.o_block  = o_block_q;
    assign bus.o_valid  = o_valid_q;
    assign bus.key_rd   = key_rd_q;
    assign bus.key_addr = round_cnt;
    assign bus.r_mode   = mode_q;
    assign bus.r_block  = block_q;
    assign bus.r_key    = key_q;
    assign bus.r_valid  = r_valid_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_simon_round_ctrl
//
// Self-checking bench for simon_round_ctrl. Provides a behavioural round-key
// store (SIMON 64/128 and 128/128 key schedules) and a behavioural round unit,
// then applies directed vectors with reference ciphertexts.
// -----------------------------------------------------------------------------
module tb_simon_round_ctrl;

    localparam logic [127:0] PT64  = {64'h1234_5678_9abc_def0, 64'h656b696c20646e75};
    localparam logic [127:0] CT64  = {64'h0, 64'h44c8fc20b9dfa07a};
    localparam logic [127:0] PT128 = 128'h63736564207372656c6c657661727420;
    localparam logic [127:0] CT128 = 128'h49681b1e1e54fe3f65aa832af84e0bbc;
    localparam logic [127:0] JUNK  = 128'hdead_beef_cafe_f00d_0123_4567_89ab_cdef;

    logic ck = 1'b0;
    logic nrst;

    simon_round_ctrl_if bus ();

    simon_round_ctrl dut (
        .ck   (ck),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 ck = ~ck;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- models
    logic [31:0] ks64  [0:43];
    logic [63:0] ks128 [0:67];
    logic [63:0] key_mem [0:67];

    logic         r_done_m   = 1'b0;
    logic [127:0] r_result_m = '0;
    logic         inj_done   = 1'b0;

    function automatic logic [31:0] rol32(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction
    function automatic logic [31:0] ror32(input logic [31:0] v, input int s);
        return (v >> s) | (v << (32 - s));
    endfunction
    function automatic logic [63:0] rol64(input logic [63:0] v, input int s);
        return (v << s) | (v >> (64 - s));
    endfunction
    function automatic logic [63:0] ror64(input logic [63:0] v, input int s);
        return (v >> s) | (v << (64 - s));
    endfunction

    // One SIMON round. Mode 0 returns junk in the upper half on purpose.
    function automatic logic [127:0] simon_round(input logic m, input logic [127:0] b,
                                                 input logic [63:0] k);
        logic [31:0] x32, y32;
        logic [63:0] x64, y64;
        if (!m) begin
            x32 = b[63:32];
            y32 = b[31:0];
            return {64'hdead_beef_0bad_f00d,
                    y32 ^ ((rol32(x32, 1) & rol32(x32, 8)) ^ rol32(x32, 2)) ^ k[31:0], x32};
        end
        x64 = b[127:64];
        y64 = b[63:0];
        return {y64 ^ ((rol64(x64, 1) & rol64(x64, 8)) ^ rol64(x64, 2)) ^ k, x64};
    endfunction

    task automatic build_schedules();
        logic [0:61] z2;
        logic [0:61] z3;
        logic [31:0] t32;
        logic [63:0] t64;
        z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
        z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
        ks64[0] = 32'h03020100;
        ks64[1] = 32'h0b0a0908;
        ks64[2] = 32'h13121110;
        ks64[3] = 32'h1b1a1918;
        for (int i = 4; i < 44; i++) begin
            t32 = ror32(ks64[i-1], 3) ^ ks64[i-3];
            t32 = t32 ^ ror32(t32, 1);
            ks64[i] = ~ks64[i-4] ^ t32 ^ {31'b0, z3[(i-4) % 62]} ^ 32'd3;
        end
        ks128[0] = 64'h0706050403020100;
        ks128[1] = 64'h0f0e0d0c0b0a0908;
        for (int i = 2; i < 68; i++) begin
            t64 = ror64(ks128[i-1], 3);
            t64 = t64 ^ ror64(t64, 1);
            ks128[i] = ~ks128[i-2] ^ t64 ^ {63'b0, z2[(i-2) % 62]} ^ 64'd3;
        end
    endtask

    // Mode 0 entries carry junk in the upper 32 bits to exercise key masking.
    task automatic load_keys(input logic m);
        for (int i = 0; i < 68; i++) begin
            if (m)
                key_mem[i] = ks128[i];
            else if (i < 44)
                key_mem[i] = {32'(32'ha5a5_0000 + i), ks64[i]};
            else
                key_mem[i] = 64'hffff_ffff_ffff_ffff;
        end
    endtask

    // Key store: data only valid in the cycle after the strobe.
    always @(posedge ck)
        bus.key_data <= bus.key_rd ? key_mem[bus.key_addr] : 64'hbad0_bad0_bad0_bad0;

    // Round unit: r_done one cycle after acceptance.
    always @(posedge ck) begin
        r_done_m <= 1'b0;
        if (bus.r_valid && bus.r_ready) begin
            r_result_m <= simon_round(bus.r_mode, bus.r_block, bus.r_key);
            r_done_m   <= 1'b1;
        end
    end

    assign bus.r_done   = r_done_m | inj_done;
    assign bus.r_result = inj_done ? JUNK : r_result_m;

    // Monitors.
    logic [6:0] key_log[$];
    int         hi_errs = 0;

    always @(posedge ck) begin
        if (nrst && bus.key_rd)
            key_log.push_back(bus.key_addr);
        if (nrst && bus.r_valid && bus.r_ready && !bus.r_mode &&
            (bus.r_key[63:32] != 32'h0 || bus.r_block[127:64] != 64'h0))
            hi_errs++;
    end

    // ---------------------------------------------------------------- tasks
    // Presents a block at a falling edge; returns #1 after the acceptance edge
    // and then flips mode, which the controller must ignore.
    task automatic start_block(input logic m, input logic [127:0] pt);
        @(negedge ck);
        check("i_ready_idle", bus.i_ready, 1'b1);
        bus.mode    = m;
        bus.i_block = pt;
        bus.i_valid = 1'b1;
        @(posedge ck);
        #1;
        bus.i_valid = 1'b0;
        bus.mode    = ~m;
        check("r_mode_latched", bus.r_mode, m);
    endtask

    // lat counts clock edges starting with the acceptance edge as 1.
    task automatic wait_out(output logic [127:0] ct, output int lat);
        lat = 1;
        while (!bus.o_valid && lat < 1000) begin
            @(posedge ck);
            #1;
            lat++;
        end
        check("o_valid_seen", bus.o_valid, 1'b1);
        ct = bus.o_block;
    endtask

    task automatic finish_out();
        @(posedge ck);
        #1;
        check("o_valid_drop", bus.o_valid, 1'b0);
        check("i_ready_back", bus.i_ready, 1'b1);
    endtask

    task automatic check_key_sweep(input string tag, input int k0, input int n);
        int errs;
        errs = 0;
        for (int i = 0; i < n && k0 + i < key_log.size(); i++)
            if (key_log[k0 + i] != 7'(i)) errs++;
        check({tag, "_count"}, 128'(key_log.size() - k0), 128'(n));
        check({tag, "_order"}, 128'(errs), 128'd0);
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        logic [127:0] ct, ob, rb;
        logic [63:0]  rk;
        int           lat, k0, h0, found, ov;

        build_schedules();
        nrst         = 1'b0;
        bus.mode     = 1'b0;
        bus.i_block  = '0;
        bus.i_valid  = 1'b0;
        bus.o_ready  = 1'b1;
        bus.r_ready  = 1'b1;
        load_keys(1'b0);

        // Reset state.
        repeat (3) @(posedge ck);
        #1;
        check("rst_i_ready",  bus.i_ready,  1'b1);
        check("rst_o_valid",  bus.o_valid,  1'b0);
        check("rst_key_rd",   bus.key_rd,   1'b0);
        check("rst_r_valid",  bus.r_valid,  1'b0);
        check("rst_key_addr", bus.key_addr, 7'd0);
        check("rst_o_block",  bus.o_block,  128'd0);
        check("rst_r_block",  bus.r_block,  128'd0);
        check("rst_r_key",    bus.r_key,    64'd0);
        check("rst_r_mode",   bus.r_mode,   1'b0);
        @(negedge ck);
        nrst = 1'b1;

        // Spurious r_done while idle.
        @(negedge ck);
        inj_done = 1'b1;
        @(negedge ck);
        inj_done = 1'b0;
        @(negedge ck);
        check("idle_done_i_ready",   bus.i_ready,     1'b1);
        check("idle_done_key_rd",    bus.key_rd,      1'b0);
        check("idle_done_r_valid",   bus.r_valid,     1'b0);
        check("idle_done_r_block",   bus.r_block,     128'd0);
        check("idle_done_round_cnt", dut.round_cnt,   7'd0);

        // Mode 0 reference vector, junk in the plaintext upper half.
        load_keys(1'b0);
        k0 = key_log.size();
        h0 = hi_errs;
        start_block(1'b0, PT64);
        wait_out(ct, lat);
        check("m0_ct",      ct,        CT64);
        check("m0_latency", 128'(lat), 128'd177);
        check("m0_r_mode",  bus.r_mode, 1'b0);
        finish_out();
        check_key_sweep("m0_keys", k0, 44);
        check("m0_upper_zero", 128'(hi_errs - h0), 128'd0);

        // Mode 1 reference vector.
        load_keys(1'b1);
        k0 = key_log.size();
        start_block(1'b1, PT128);
        wait_out(ct, lat);
        check("m1_ct",      ct,         CT128);
        check("m1_latency", 128'(lat),  128'd273);
        check("m1_r_mode",  bus.r_mode, 1'b1);
        finish_out();
        check_key_sweep("m1_keys", k0, 68);

        // r_ready stall on round 3, with a spurious r_done inside ISSUE.
        load_keys(1'b0);
        fork
            begin
                start_block(1'b0, PT64);
                wait_out(ct, lat);
            end
            begin
                found = 0;
                for (int c = 0; c < 500 && found == 0; c++) begin
                    @(negedge ck);
                    if (bus.r_valid && bus.key_addr == 7'd3) found = 1;
                end
                check("stall_reached", 128'(found), 128'd1);
                bus.r_ready = 1'b0;
                rb = bus.r_block;
                rk = bus.r_key;
                for (int s = 0; s < 5; s++) begin
                    inj_done = (s == 2);
                    @(negedge ck);
                    check("stall_r_valid", bus.r_valid,  1'b1);
                    check("stall_r_block", bus.r_block,  rb);
                    check("stall_r_key",   bus.r_key,    rk);
                    check("stall_round",   bus.key_addr, 7'd3);
                end
                inj_done    = 1'b0;
                bus.r_ready = 1'b1;
            end
        join
        check("stall_ct", ct, CT64);
        finish_out();

        // o_ready held low for 10 cycles; input side toggles are ignored.
        load_keys(1'b1);
        bus.o_ready = 1'b0;
        start_block(1'b1, PT128);
        wait_out(ct, lat);
        check("hold_ct", ct, CT128);
        ob = bus.o_block;
        for (int s = 0; s < 10; s++) begin
            bus.mode    = ~bus.mode;
            bus.i_valid = ~bus.i_valid;
            @(posedge ck);
            #1;
            check("hold_o_valid", bus.o_valid, 1'b1);
            check("hold_o_block", bus.o_block, ob);
            check("hold_i_ready", bus.i_ready, 1'b0);
        end
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
        finish_out();

        // Reset during WAIT_RES of round 20, then a fresh block.
        load_keys(1'b0);
        start_block(1'b0, PT64);
        found = 0;
        for (int c = 0; c < 1000 && found == 0; c++) begin
            @(negedge ck);
            if (bus.r_valid && bus.r_ready && bus.key_addr == 7'd20) found = 1;
        end
        check("rst20_reached", 128'(found), 128'd1);
        @(negedge ck);
        nrst = 1'b0;
        @(posedge ck);
        #1;
        check("rst20_i_ready",   bus.i_ready,   1'b1);
        check("rst20_o_valid",   bus.o_valid,   1'b0);
        check("rst20_key_rd",    bus.key_rd,    1'b0);
        check("rst20_r_valid",   bus.r_valid,   1'b0);
        check("rst20_key_addr",  bus.key_addr,  7'd0);
        check("rst20_o_block",   bus.o_block,   128'd0);
        check("rst20_r_block",   bus.r_block,   128'd0);
        check("rst20_r_key",     bus.r_key,     64'd0);
        check("rst20_r_mode",    bus.r_mode,    1'b0);
        @(negedge ck);
        nrst = 1'b1;
        ov = 0;
        repeat (200) begin
            @(negedge ck);
            if (bus.o_valid || bus.key_rd) ov++;
        end
        check("rst20_quiet", 128'(ov), 128'd0);
        start_block(1'b0, PT64);
        wait_out(ct, lat);
        check("rst20_ct",      ct,        CT64);
        check("rst20_latency", 128'(lat), 128'd177);
        finish_out();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
